sync_prefill_fifo: RTL and testbench

Single-clock, parametrised FIFO with a runtime-programmable pre-fill gate, a drain mode, occupancy reporting and sticky error flags. It replaces the dual-clock pre-fill FIFO on paths where producer and consumer share one clock, such as line-buffer feeds into the convolution PE array. In those paths the consumer must not start until a minimum number of words is buffered. Both sides use valid/ready handshakes.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_ram_1r1w.sv | 26 ++
 rtl/sync_prefill_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_sync_prefill_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for the single-clock pre-fill FIFO.
// Pointers are passed zero-extended to 32 bits so one helper serves every depth.
package fifo_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } fifo_state_e;

    function automatic logic ptr_empty(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr);
        return (wr_ptr == rd_ptr);
    endfunction

    // Full: index bits match while the wrap bits differ.
    function automatic logic ptr_full(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr,
                                      input int addr_width);
        logic [31:0] diff;
        logic [31:0] idx_mask;
        diff     = wr_ptr ^ rd_ptr;
        idx_mask = (32'd1 << addr_width) - 32'd1;
        return ((diff & idx_mask) == 32'd0) && (diff[addr_width] == 1'b1);
    endfunction

    function automatic logic [31:0] ptr_count(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr,
                                              input int addr_width);
        return (wr_ptr - rd_ptr) & ((32'd1 << (addr_width + 1)) - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// DEPTH x DATA_WIDTH register array: synchronous write port, asynchronous read port.
module fifo_ram_1r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_prefill_fifo.sv
// Single-clock FIFO whose consumer side is gated until a programmable fill level
// is reached, with a drain mode, occupancy reporting and sticky error flags.
module sync_prefill_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int ADDR_WIDTH     = $clog2(FIFO_DEPTH),
    parameter int PRE_FILL_LEVEL = FIFO_DEPTH / 2,
    parameter int AFULL_LEVEL    = FIFO_DEPTH - 2,
    parameter int REARM          = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic [ADDR_WIDTH:0]   prefill_level,
    input  logic                  cfg_load,
    input  logic                  drain,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  prefill_done,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] thr_q, thr_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    fifo_state_e      state_q, state_d;

    logic [PTR_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             prefill_done_s;

    assign count_s = PTR_W'(ptr_count(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_WIDTH));
    assign full_s  = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_WIDTH);
    assign empty_s = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q));
    assign push_s  = in_valid & in_ready_s;
    assign pop_s   = out_valid_s & out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other request.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (drain) begin
                        state_d = DRAIN;
                    end else if (count_s >= thr_q) begin
                        state_d = STREAM;
                    end else begin
                        state_d = FILL;
                    end
                end
                STREAM: begin
                    if (drain) begin
                        state_d = DRAIN;
                    end else if ((REARM != 0) && pop_s && !push_s && (count_s == PTR_W'(1))) begin
                        state_d = FILL;
                    end else begin
                        state_d = STREAM;
                    end
                end
                DRAIN: begin
                    if (empty_s) begin
                        state_d = FILL;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // Handshake outputs decoded from state and registered occupancy only.
    always_comb begin
        out_valid_s    = 1'b0;
        in_ready_s     = 1'b0;
        prefill_done_s = 1'b0;
        case (state_q)
            FILL: begin
                in_ready_s = !full_s;
            end
            STREAM: begin
                out_valid_s    = !empty_s;
                in_ready_s     = !full_s;
                prefill_done_s = 1'b1;
            end
            DRAIN: begin
                out_valid_s    = !empty_s;
                prefill_done_s = 1'b1;
            end
            default: begin
                out_valid_s    = 1'b0;
                in_ready_s     = 1'b0;
                prefill_done_s = 1'b0;
            end
        endcase
    end

    // Pointer, threshold and sticky-flag next values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        thr_d    = thr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (cfg_load) begin
                if (prefill_level > PTR_W'(FIFO_DEPTH)) begin
                    thr_d = PTR_W'(FIFO_DEPTH);
                end else begin
                    thr_d = prefill_level;
                end
            end else begin
                thr_d = thr_q;
            end
            if (in_valid && (full_s || (state_q == DRAIN))) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (out_ready && !out_valid_s && (state_q == STREAM)) begin
                udf_d = 1'b1;
            end else begin
                udf_d = udf_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            thr_q    <= PTR_W'(PRE_FILL_LEVEL);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            thr_q    <= thr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push_s & ~flush),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (out_data)
    );

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_s;
    assign count        = count_s;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_s >= PTR_W'(AFULL_LEVEL));
    assign prefill_done = prefill_done_s;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_prefill_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model of the pre-fill FIFO.
module tb_sync_prefill_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [AW:0]   prefill_level;
    logic          cfg_load;
    logic          drain;
    logic          flush;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          prefill_done;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    sync_prefill_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .prefill_level (prefill_level),
        .cfg_load      (cfg_load),
        .drain         (drain),
        .flush         (flush),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .prefill_done  (prefill_done),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    int chk_total = 0;
    int chk_pass  = 0;

    // Reference model: contents queue, threshold, gate/drain modes, sticky flags.
    logic [DW-1:0] mq[$];
    int            m_thr;
    bit            m_stream;
    bit            m_drain;
    bit            m_ovf;
    bit            m_udf;
    logic [DW-1:0] seq_data = 8'd0;

    function automatic bit exp_valid();
        return (m_stream || m_drain) && (mq.size() != 0);
    endfunction

    function automatic bit exp_ready();
        return (mq.size() < DEPTH) && !m_drain;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_total++;
        if (got === exp) begin
            chk_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_thr    = DEPTH / 2;
        m_stream = 1'b0;
        m_drain  = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
    endtask

    task automatic model_step(input bit iv, input logic [DW-1:0] id, input bit ordy,
                              input logic [AW:0] pl, input bit cl, input bit dr, input bit fl);
        int cnt;
        bit ev;
        bit push;
        bit pop;
        cnt  = mq.size();
        ev   = exp_valid();
        push = iv && exp_ready();
        pop  = ev && ordy;
        if (fl) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_stream = 1'b0;
            m_drain  = 1'b0;
        end else begin
            if (iv && ((cnt == DEPTH) || m_drain)) m_ovf = 1'b1;
            if (ordy && !ev && m_stream) m_udf = 1'b1;
            if (m_drain) begin
                if (cnt == 0) m_drain = 1'b0;
            end else if (m_stream) begin
                if (dr) begin
                    m_stream = 1'b0;
                    m_drain  = 1'b1;
                end else if (pop && !push && (cnt == 1)) begin
                    m_stream = 1'b0;
                end
            end else begin
                if (dr) m_drain = 1'b1;
                else if (cnt >= m_thr) m_stream = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(id);
            if (cl) m_thr = (int'(pl) > DEPTH) ? DEPTH : int'(pl);
        end
    endtask

    task automatic check_all();
        int c;
        c = mq.size();
        check_val("count",        32'(count),        32'(c));
        check_val("empty",        32'(empty),        32'(c == 0));
        check_val("full",         32'(full),         32'(c == DEPTH));
        check_val("almost_full",  32'(almost_full),  32'(c >= DEPTH - 2));
        check_val("in_ready",     32'(in_ready),     32'(exp_ready()));
        check_val("out_valid",    32'(out_valid),    32'(exp_valid()));
        check_val("prefill_done", 32'(prefill_done), 32'(m_stream || m_drain));
        check_val("overflow",     32'(overflow),     32'(m_ovf));
        check_val("underflow",    32'(underflow),    32'(m_udf));
        if (exp_valid()) begin
            check_val("out_data", 32'(out_data), 32'(mq[0]));
        end
    endtask

    task automatic cycle(input bit iv, input logic [DW-1:0] id, input bit ordy,
                         input logic [AW:0] pl, input bit cl, input bit dr, input bit fl);
        in_valid      = iv;
        in_data       = id;
        out_ready     = ordy;
        prefill_level = pl;
        cfg_load      = cl;
        drain         = dr;
        flush         = fl;
        model_step(iv, id, ordy, pl, cl, dr, fl);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, seq_data, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            seq_data = seq_data + 8'd1;
        end
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 8'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = 8'd0;
        out_ready     = 1'b0;
        prefill_level = 5'd0;
        cfg_load      = 1'b0;
        drain         = 1'b0;
        flush         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Default threshold 8: gate holds for 7 words, opens one cycle after the 8th.
        push_n(7);
        push_n(1);
        idle();
        pop_n(8);
        idle();

        // Threshold 0: no gating, then a long push/pop run that wraps the pointers.
        cycle(1'b0, 8'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        push_n(1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, seq_data, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
            seq_data = seq_data + 8'd1;
        end
        pop_n(1);
        idle();
        pop_n(1);
        cycle(1'b0, 8'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Clamped threshold 16 survives flush; fill to full, then refused push with pop.
        push_n(16);
        idle();
        cycle(1'b1, seq_data, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("full_refuse_count", 32'(count), 32'd15);

        // Drain three words from FILL; a push during drain flags overflow.
        cycle(1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        push_n(3);
        cycle(1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        pop_n(2);
        idle();
        idle();
        cycle(1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Flush with 10 words held while push, pop and cfg_load are all active.
        push_n(10);
        cycle(1'b1, 8'h55, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
        push_n(8);
        idle();
        pop_n(8);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(99) < 60), 8'($urandom), ($urandom_range(99) < 50),
                  5'($urandom_range(31)), ($urandom_range(99) < 3),
                  ($urandom_range(99) < 2), ($urandom_range(99) < 2));
        end

        // Asynchronous reset mid-stream: outputs return to reset values before the next edge.
        cycle(1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        push_n(9);
        idle();
        pop_n(2);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
        push_n(8);
        idle();
        pop_n(8);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
